// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel pack writer.
//   state_e          : frame FSM states
//   LANES            : pixels (bytes) per 32-bit output word
//   DEF_FRAME_PIXELS : default frame size (640x480)
//   CNT_W            : width of the per-frame pixel counter
package pixel_writer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DONE} state_e;
  localparam int LANES            = 4;
  localparam int DEF_FRAME_PIXELS = 307200;
  localparam int CNT_W            = 19;
endpackage

// File: rtl/pixel_pack_writer_word_packer.sv
// word_packer: collects bytes little-endian into one pack register and
// hands out completed (or final partial) words with their lane enables.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : frame start, empties the packer
//   acc_i, pix_i : accepted pixel strobe and byte
//   last_i       : accepted pixel is the final one of the frame
//   out_free_i   : output register can take a word on this edge
//   word_vld_o   : a word is available this cycle (word_o / be_o)
//   full_o       : pack register holds a complete word awaiting transfer
module word_packer
  import pixel_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic [7:0]  pix_i,
  input  logic        last_i,
  input  logic        out_free_i,
  output logic        word_vld_o,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        full_o
);
  logic [1:0]  lane_q;
  logic [31:0] pack_q;
  logic [3:0]  be_q;
  logic        full_q;
  logic [31:0] cur_word;
  logic [3:0]  cur_be;
  logic        new_word;

  // Current pack contents with the incoming byte merged into its lane,
  // so a completing word can bypass straight to the output register.
  always_comb begin
    cur_word = pack_q;
    cur_word[lane_q*8 +: 8] = pix_i;
    case (lane_q)
      2'd0:    cur_be = 4'b0001;
      2'd1:    cur_be = 4'b0011;
      2'd2:    cur_be = 4'b0111;
      default: cur_be = 4'b1111;
    endcase
  end

  assign new_word   = acc_i && (lane_q == 2'(LANES-1) || last_i);
  assign word_vld_o = full_q || new_word;
  assign word_o     = full_q ? pack_q : cur_word;
  assign be_o       = full_q ? be_q : cur_be;
  assign full_o     = full_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      lane_q <= '0;
      pack_q <= '0;
      be_q   <= '0;
      full_q <= 1'b0;
    end else if (full_q) begin
      // no pixels are accepted while full; just wait for the hand-off
      if (out_free_i) begin
        full_q <= 1'b0;
        pack_q <= '0;
        be_q   <= '0;
      end
    end else if (acc_i) begin
      if (new_word) begin
        lane_q <= '0;
        if (out_free_i) begin
          pack_q <= '0;
        end else begin
          pack_q <= cur_word;
          be_q   <= cur_be;
          full_q <= 1'b1;
        end
      end else begin
        pack_q <= cur_word;
        lane_q <= lane_q + 2'd1;
      end
    end
  end
endmodule

// File: rtl/pixel_pack_writer.sv
// pixel_pack_writer: accepts a frame of 8-bit Sobel magnitudes, packs four
// per 32-bit word and writes them to consecutive byte addresses.
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a frame (IDLE only)
//   pix_valid/pix_data : pixel input, accepted when pix_valid & pix_ready
//   wr_en/wr_addr/wr_data/byte_en : write request, held while wr_wait=1
//   busy, frame_done, pix_count   : frame status
// Build option: PIXEL_WRITER_THRESHOLD_EN binarises each pixel against
// THRESH (0xFF if >= THRESH, else 0x00) before packing.
module pixel_pack_writer
  import pixel_writer_pkg::*;
#(
  parameter int          FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [7:0]  THRESH       = 8'd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [3:0]       byte_en,
  input  logic             wr_wait,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count
);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_PIXELS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pix_count_q;
  logic              wr_en_q;
  logic [31:0]       wr_addr_q, nxt_addr_q, wr_data_q;
  logic [3:0]        byte_en_q;
  logic [7:0]        pix_byte;
  logic              accept, last, out_free, load, frame_go;
  logic              pk_vld, pk_full;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;

`ifdef PIXEL_WRITER_THRESHOLD_EN
  assign pix_byte = (pix_data >= THRESH) ? 8'hFF : 8'h00;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign pix_byte      = pix_data;
`endif

  assign frame_go  = (state_q == ST_IDLE) && start;
  assign pix_ready = (state_q == ST_ACCUM) && !pk_full && (pix_count_q < FRAME_CNT);
  assign accept    = pix_valid && pix_ready;
  assign last      = (pix_count_q == LAST_CNT);
  // output register is free if empty or its write completes on this edge
  assign out_free  = !wr_en_q || !wr_wait;
  assign load      = pk_vld && out_free;

  word_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (frame_go),
    .acc_i      (accept),
    .pix_i      (pix_byte),
    .last_i     (last),
    .out_free_i (out_free),
    .word_vld_o (pk_vld),
    .word_o     (pk_word),
    .be_o       (pk_be),
    .full_o     (pk_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && last) state_d = ST_FLUSH;
      ST_FLUSH: if (!pk_full && !wr_en_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pix_count_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      nxt_addr_q  <= BASE_ADDR;
      wr_data_q   <= '0;
      byte_en_q   <= '0;
    end else begin
      state_q <= state_d;
      if (frame_go) pix_count_q <= '0;
      else if (accept) pix_count_q <= pix_count_q + 1'b1;
      // wr_addr tracks the word in the output register; the next word's
      // address is precomputed so it is ready on the load edge
      if (frame_go) nxt_addr_q <= BASE_ADDR;
      else if (load) nxt_addr_q <= nxt_addr_q + 32'd4;
      if (load) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= nxt_addr_q;
        wr_data_q <= pk_word;
        byte_en_q <= pk_be;
      end else if (out_free) begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign byte_en    = byte_en_q;
  assign busy       = (state_q == ST_ACCUM) || (state_q == ST_FLUSH);
  assign frame_done = (state_q == ST_DONE);
  assign pix_count  = pix_count_q;
endmodule

// File: tb/tb_pixel_pack_writer.sv
module tb_pixel_pack_writer;
  localparam logic [31:0] BA = 32'h1000_0000;
  localparam logic [31:0] BB = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_start = 0, a_valid = 0, a_wait = 0;
  logic [7:0] a_data = 0;
  logic a_ready, a_wr_en, a_busy, a_done;
  logic [31:0] a_addr, a_wdata;
  logic [3:0] a_be;
  logic [18:0] a_cnt;

  logic b_start = 0, b_valid = 0, b_wait = 0;
  logic [7:0] b_data = 0;
  logic b_ready, b_wr_en, b_busy, b_done;
  logic [31:0] b_addr, b_wdata;
  logic [3:0] b_be;
  logic [18:0] b_cnt;

  pixel_pack_writer #(.FRAME_PIXELS(8), .BASE_ADDR(BA), .THRESH(8'd64)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .pix_valid(a_valid), .pix_data(a_data),
    .pix_ready(a_ready), .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_wdata),
    .byte_en(a_be), .wr_wait(a_wait), .busy(a_busy), .frame_done(a_done),
    .pix_count(a_cnt));

  pixel_pack_writer #(.FRAME_PIXELS(6), .BASE_ADDR(BB), .THRESH(8'd64)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .pix_valid(b_valid), .pix_data(b_data),
    .pix_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_wdata),
    .byte_en(b_be), .wr_wait(b_wait), .busy(b_busy), .frame_done(b_done),
    .pix_count(b_cnt));

  int nchk = 0, nbad = 0;
  logic [67:0] qa[$], qb[$];

  // completed writes: wr_en high with wr_wait low at the next rising edge
  always @(negedge clk) begin
    if (a_wr_en && !a_wait) qa.push_back({a_addr, a_wdata, a_be});
    if (b_wr_en && !b_wait) qb.push_back({b_addr, b_wdata, b_be});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] p);
`ifdef PIXEL_WRITER_THRESHOLD_EN
    return (p >= 8'd64) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  function automatic logic [31:0] w4(input logic [7:0] p0, p1, p2, p3);
    return {xf(p3), xf(p2), xf(p1), xf(p0)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] d);
    int n = 0;
    if (sel) begin b_data = d; b_valid = 1; end
    else begin a_data = d; a_valid = 1; end
    while (!(sel ? b_ready : a_ready) && n < 50) begin tick(); n++; end
    chk("send_ready", sel ? b_ready : a_ready, 1);
    tick();
    if (sel) b_valid = 0; else a_valid = 0;
  endtask

  task automatic go(input bit sel);
    if (sel) b_start = 1; else a_start = 1;
    tick();
    if (sel) b_start = 0; else a_start = 0;
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while (!(sel ? b_done : a_done) && n < 100) begin tick(); n++; end
    chk("frame_done", sel ? b_done : a_done, 1);
    tick();
    chk("done_pulse", sel ? b_done : a_done, 0);
    chk("busy_after", sel ? b_busy : a_busy, 0);
  endtask

  task automatic chk_wr(input bit sel, input int i, input logic [31:0] ad, wd,
                        input logic [3:0] be);
    logic [67:0] e;
    int sz;
    sz = sel ? qb.size() : qa.size();
    chk($sformatf("wr%0d_seen", i), sz > i, 1);
    if (sz > i) begin
      e = sel ? qb[i] : qa[i];
      chk($sformatf("wr%0d_addr", i), e[67:36], ad);
      chk($sformatf("wr%0d_data", i), e[35:4], wd);
      chk($sformatf("wr%0d_be", i), {28'd0, e[3:0]}, {28'd0, be});
    end
  endtask

  initial begin
    // reset values
    tick(); tick();
    rst = 0;
    chk("rst_ready", a_ready, 0);
    chk("rst_wr_en", a_wr_en, 0);
    chk("rst_addr", a_addr, BA);
    chk("rst_data", a_wdata, 0);
    chk("rst_be", a_be, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_addr_b", b_addr, BB);

    // frame 1: 8 pixels streamed, no stall
    go(0);
    chk("busy_accum", a_busy, 1);
    chk("ready_accum", a_ready, 1);
    send(0, 8'h01); send(0, 8'h02);
    a_start = 1;                       // ignored while in ACCUM
    send(0, 8'h03);
    a_start = 0;
    chk("cnt_start_ign", a_cnt, 3);
    send(0, 8'h04);
    chk("lat_wr_en", a_wr_en, 1);
    chk("lat_data", a_wdata, w4(8'h01, 8'h02, 8'h03, 8'h04));
    send(0, 8'h05); send(0, 8'h06); send(0, 8'h07); send(0, 8'h08);
    wait_done(0);
    chk("cnt_frame", a_cnt, 8);
    chk_wr(0, 0, BA, w4(8'h01, 8'h02, 8'h03, 8'h04), 4'hF);
    chk_wr(0, 1, BA + 4, w4(8'h05, 8'h06, 8'h07, 8'h08), 4'hF);

    // pixels offered in IDLE are ignored
    a_valid = 1; a_data = 8'h55;
    tick(); tick(); tick();
    a_valid = 0;
    chk("idle_cnt", a_cnt, 8);
    chk("idle_writes", qa.size(), 2);

    // frame 2: first write stalled for 5 cycles while pixels keep coming
    a_wait = 1;
    go(0);
    send(0, 8'h21); send(0, 8'h22); send(0, 8'h23); send(0, 8'h24);
    for (int i = 0; i < 4; i++) begin
      chk("stall_wr_en", a_wr_en, 1);
      chk("stall_data", a_wdata, w4(8'h21, 8'h22, 8'h23, 8'h24));
      chk("stall_addr", a_addr, BA);
      send(0, 8'h25 + 8'(i));
    end
    chk("stall_ready", a_ready, 0);
    chk("stall_cnt", a_cnt, 8);
    tick();
    chk("stall5_data", a_wdata, w4(8'h21, 8'h22, 8'h23, 8'h24));
    chk("stall5_wr_en", a_wr_en, 1);
    a_wait = 0;
    tick();
    // completion and reload on the same edge: no bubble
    chk("b2b_wr_en", a_wr_en, 1);
    chk("b2b_data", a_wdata, w4(8'h25, 8'h26, 8'h27, 8'h28));
    chk("b2b_addr", a_addr, BA + 4);
    wait_done(0);
    chk_wr(0, 2, BA, w4(8'h21, 8'h22, 8'h23, 8'h24), 4'hF);
    chk_wr(0, 3, BA + 4, w4(8'h25, 8'h26, 8'h27, 8'h28), 4'hF);

    // reset mid-frame with a write pending
    a_wait = 1;
    go(0);
    send(0, 8'h11); send(0, 8'h12); send(0, 8'h13); send(0, 8'h14); send(0, 8'h15);
    rst = 1;
    tick();
    rst = 0;
    chk("mrst_wr_en", a_wr_en, 0);
    chk("mrst_addr", a_addr, BA);
    chk("mrst_data", a_wdata, 0);
    chk("mrst_be", a_be, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_cnt", a_cnt, 0);
    chk("mrst_ready", a_ready, 0);
    a_wait = 0;
    tick(); tick(); tick();
    chk("mrst_nowrite", qa.size(), 4);
    chk("mrst_idle", a_busy, 0);
    go(0);
    for (int i = 0; i < 8; i++) send(0, 8'h31 + 8'(i));
    wait_done(0);
    chk_wr(0, 4, BA, w4(8'h31, 8'h32, 8'h33, 8'h34), 4'hF);
    chk_wr(0, 5, BA + 4, w4(8'h35, 8'h36, 8'h37, 8'h38), 4'hF);
    chk("mrst_total", qa.size(), 6);

`ifdef PIXEL_WRITER_THRESHOLD_EN
    go(0);
    send(0, 8'd63); send(0, 8'd64); send(0, 8'd200); send(0, 8'd0);
    for (int i = 0; i < 4; i++) send(0, 8'd100);
    wait_done(0);
    chk_wr(0, 6, BA, 32'h00FF_FF00, 4'hF);
    chk_wr(0, 7, BA + 4, 32'hFFFF_FFFF, 4'hF);
`endif

    // partial last word on a 6-pixel frame, address wraps past 2^32
    go(1);
    for (int i = 0; i < 6; i++) send(1, 8'h10 + 8'(i));
    wait_done(1);
    chk("b_cnt", b_cnt, 6);
    chk_wr(1, 0, BB, w4(8'h10, 8'h11, 8'h12, 8'h13), 4'hF);
    chk_wr(1, 1, 32'h0000_0000, {16'h0000, xf(8'h15), xf(8'h14)}, 4'b0011);
    chk("b_total", qb.size(), 2);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
